// File: rtl/iter_counter.sv
// Programmable iteration counter for the MultDiv datapath.
// Latches a limit on start, steps q on enabled cycles and strobes done.
module iter_counter #(
  parameter int WIDTH        = 6,
  parameter bit AUTO_RESTART = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] limit,
  input  logic             en,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             last,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] lim_r;
  logic [WIDTH-1:0] lim_n;
  logic [WIDTH-1:0] q_n;
  logic             done_n;
  logic [WIDTH-1:0] lim_m1;
  logic             at_end;
  logic             in_run;
  logic             accept;
  logic             lim_zero;
  logic             term;

  assign in_run   = (state == S_RUN);
  assign lim_m1   = lim_r - WIDTH'(1);
  assign at_end   = (lim_r != '0) && (q == lim_m1);
  assign accept   = start && !in_run;
  assign lim_zero = (limit == '0);
  assign term     = in_run && en && at_end;

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= S_IDLE;
      q     <= '0;
      lim_r <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      q     <= q_n;
      lim_r <= lim_n;
      done  <= done_n;
    end
  end

  // abort outranks start in every state, so a stray abort
  // in IDLE swallows a coincident start.
  always_comb begin
    state_n = state;
    if (abort) begin
      state_n = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (accept && !lim_zero) state_n = S_RUN;
          else                     state_n = S_IDLE;
        end
        S_RUN: begin
          if (term && !AUTO_RESTART) state_n = S_DONE;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_comb begin
    q_n    = q;
    lim_n  = lim_r;
    done_n = 1'b0;
    if (abort) begin
      if (state != S_IDLE) q_n = '0;
    end else if (accept) begin
      if (lim_zero) begin
        done_n = 1'b1;
      end else begin
        lim_n = limit;
        q_n   = '0;
      end
    end else if (in_run && en) begin
      if (at_end) begin
        done_n = 1'b1;
        if (AUTO_RESTART) q_n = '0;
      end else begin
        q_n = q + WIDTH'(1);
      end
    end
  end

  always_comb begin
    busy = in_run;
    last = in_run && at_end;
  end

endmodule

// File: tb/tb_iter_counter.sv
// Directed bench for iter_counter: one-shot and auto-restart builds
// driven from a shared stimulus sequence.
module tb_iter_counter;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         clr, start, en, abort;
  logic [W-1:0] limit;
  logic [W-1:0] q, q_ar;
  logic         busy, last, done;
  logic         busy_ar, last_ar, done_ar;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  iter_counter #(.WIDTH(W), .AUTO_RESTART(1'b0)) dut (
    .clk(clk), .clr(clr), .start(start), .limit(limit),
    .en(en), .abort(abort),
    .q(q), .busy(busy), .last(last), .done(done)
  );

  iter_counter #(.WIDTH(W), .AUTO_RESTART(1'b1)) dut_ar (
    .clk(clk), .clr(clr), .start(start), .limit(limit),
    .en(en), .abort(abort),
    .q(q_ar), .busy(busy_ar), .last(last_ar), .done(done_ar)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; en = 1'b0; abort = 1'b0; limit = '0;
    tick();
    chk("rst_q", int'(q), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_last", int'(last), 0);
    chk("rst_done", int'(done), 0);
    clr = 1'b0;

    // full 32-iteration run
    limit = 6'd32; start = 1'b1; en = 1'b1;
    tick();
    chk("l32_q0", int'(q), 0);
    chk("l32_busy0", int'(busy), 1);
    chk("l32_last0", int'(last), 0);
    start = 1'b0;
    for (int j = 1; j <= 31; j++) begin
      tick();
      chk($sformatf("l32_q%0d", j), int'(q), j);
      chk($sformatf("l32_last%0d", j), int'(last), (j == 31) ? 1 : 0);
      chk($sformatf("l32_done%0d", j), int'(done), 0);
      chk($sformatf("l32_busy%0d", j), int'(busy), 1);
    end
    tick();
    chk("l32_term_done", int'(done), 1);
    chk("l32_term_busy", int'(busy), 0);
    chk("l32_term_q", int'(q), 31);
    chk("l32_term_last", int'(last), 0);
    tick();
    chk("l32_post_done", int'(done), 0);
    chk("l32_post_q", int'(q), 31);
    chk("l32_post_busy", int'(busy), 0);

    // limit 5 with en toggling
    limit = 6'd5; start = 1'b1; en = 1'b0;
    tick();
    chk("l5_q0", int'(q), 0);
    chk("l5_busy0", int'(busy), 1);
    start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      en = k[0];
      tick();
      if (k < 9) begin
        chk($sformatf("l5_q_k%0d", k), int'(q), (k + 1) / 2);
        chk($sformatf("l5_done_k%0d", k), int'(done), 0);
        chk($sformatf("l5_busy_k%0d", k), int'(busy), 1);
      end else if (k == 9) begin
        chk("l5_term_done", int'(done), 1);
        chk("l5_term_busy", int'(busy), 0);
        chk("l5_term_q", int'(q), 4);
      end else begin
        chk("l5_post_done", int'(done), 0);
      end
    end

    // limit 0: done pulse only
    limit = 6'd0; start = 1'b1; en = 1'b1;
    tick();
    chk("l0_done", int'(done), 1);
    chk("l0_busy", int'(busy), 0);
    chk("l0_last", int'(last), 0);
    start = 1'b0;
    tick();
    chk("l0_done2", int'(done), 0);
    chk("l0_busy2", int'(busy), 0);

    // abort at q=7
    limit = 6'd20; start = 1'b1; en = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 1; j <= 7; j++) tick();
    chk("ab_pre_q", int'(q), 7);
    abort = 1'b1;
    tick();
    chk("ab_q", int'(q), 0);
    chk("ab_busy", int'(busy), 0);
    chk("ab_done", int'(done), 0);
    abort = 1'b0;
    tick();
    chk("ab_q2", int'(q), 0);
    chk("ab_done2", int'(done), 0);
    chk("ab_busy2", int'(busy), 0);

    // clr at q=7
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 1; j <= 7; j++) tick();
    chk("cl_pre_q", int'(q), 7);
    clr = 1'b1;
    tick();
    chk("cl_q", int'(q), 0);
    chk("cl_busy", int'(busy), 0);
    chk("cl_done", int'(done), 0);
    clr = 1'b0;
    tick();
    chk("cl_q2", int'(q), 0);
    chk("cl_done2", int'(done), 0);

    // auto-restart, limit 3
    limit = 6'd3; start = 1'b1; en = 1'b1;
    tick();
    chk("ar_q0", int'(q_ar), 0);
    chk("ar_busy0", int'(busy_ar), 1);
    start = 1'b0;
    tick();
    chk("ar_q1", int'(q_ar), 1);
    tick();
    chk("ar_q2", int'(q_ar), 2);
    chk("ar_last2", int'(last_ar), 1);
    chk("ar_done2", int'(done_ar), 0);
    tick();
    chk("ar_q3", int'(q_ar), 0);
    chk("ar_done3", int'(done_ar), 1);
    chk("ar_busy3", int'(busy_ar), 1);
    tick();
    chk("ar_q4", int'(q_ar), 1);
    chk("ar_done4", int'(done_ar), 0);
    tick();
    chk("ar_q5", int'(q_ar), 2);
    tick();
    chk("ar_q6", int'(q_ar), 0);
    chk("ar_done6", int'(done_ar), 1);
    chk("ar_busy6", int'(busy_ar), 1);

    // one-shot: restart during the DONE cycle
    clr = 1'b1;
    tick();
    clr = 1'b0;
    limit = 6'd2; start = 1'b1; en = 1'b1;
    tick();
    chk("b2b_q0", int'(q), 0);
    start = 1'b0;
    tick();
    chk("b2b_q1", int'(q), 1);
    chk("b2b_last1", int'(last), 1);
    tick();
    chk("b2b_done", int'(done), 1);
    chk("b2b_busy_d", int'(busy), 0);
    limit = 6'd4; start = 1'b1;
    tick();
    chk("b2b_new_q", int'(q), 0);
    chk("b2b_new_busy", int'(busy), 1);
    chk("b2b_new_done", int'(done), 0);
    start = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      tick();
      chk($sformatf("b2b_q%0d", j), int'(q), j);
    end
    tick();
    chk("b2b_end_done", int'(done), 1);
    chk("b2b_end_q", int'(q), 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
